riscv_fetch_unit: RTL and testbench
===================================

Name: riscv_fetch_unit

Overview:
- Parameterised instruction-fetch front end for the RISC-V core; replaces the fixed 32-bit PC register and branch-target logic in the data path.
- Generates sequential fetch addresses and issues them to instruction memory over a valid/ready request channel.
- Buffers returned instructions, each tagged with its PC, in a DEPTH-entry FIFO.
- Applies taken-branch/jump redirects, flushing the FIFO and discarding stale in-flight responses.

Parameters:
XLEN, 32, PC and target address width
RESET_PC, 0, PC value loaded at reset
DEPTH, 4, max entries (buffered + in-flight); power of two, >=2

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous reset, active-low
imem_req_valid  output  1  fetch request valid
imem_req_ready  input  1  imem accepts request
imem_req_addr  output  XLEN  fetch address, word aligned
imem_rsp_valid  input  1  response valid; in order, one per accepted request, no backpressure
imem_rsp_data  input  32  instruction word
jump  input  1  jump taken
beq, bneq, bge, blt  input  1 each  branch-taken flags from data path
jump_target  input  XLEN  jump destination
branch_target  input  XLEN  branch destination
instr_valid  output  1  FIFO head valid
instr_ready  input  1  decode consumes head
instr_data  output  32  head instruction
instr_pc  output  XLEN  PC of head instruction

Behaviour:
- redirect = jump | beq | bneq | bge | blt. Target = jump_target if jump, else branch_target (jump wins). Bits [1:0] of the target are forced to 0.
- State:
  - fetch_pc: next address to request.
  - head_pc: PC of the FIFO head.
  - count: FIFO occupancy.
  - outstanding: accepted requests not yet returned.
  - drop_cnt: stale responses still to discard.
  - All counters are $clog2(DEPTH+1) bits.
- Reset (rst=0, async), all held while asserted:
  - fetch_pc = head_pc = RESET_PC.
  - count = outstanding = drop_cnt = 0.
  - imem_req_valid = 0, instr_valid = 0.
  - FIFO data don't-care.
- Request issue:
  - imem_req_valid = !redirect && (count + outstanding + drop_cnt < DEPTH); depends only on this condition, never on imem_req_ready.
  - imem_req_addr = fetch_pc.
  - On handshake: fetch_pc += 4 (wraps mod 2^XLEN); outstanding += 1.
  - One request per cycle maximum.
- Response:
  - If drop_cnt > 0: drop_cnt -= 1, data discarded.
  - Else: outstanding -= 1, word pushed to FIFO tail.
  - Credit rule guarantees the FIFO never overflows; a push into a full FIFO is a design error (assertion).
- Output:
  - instr_valid = (count != 0) && !redirect.
  - instr_data/instr_pc = head entry / head_pc.
  - Pop on instr_valid && instr_ready: head_pc += 4.
  - Latency: response accepted in cycle N appears at head no earlier than N+1 (registered FIFO, no bypass).
- Redirect (sampled at posedge):
  - fetch_pc <= target; head_pc <= target; FIFO flushed, count <= 0.
  - drop_cnt <= drop_cnt + outstanding - (imem_rsp_valid ? 1 : 0); outstanding <= 0.
  - The response arriving in the redirect cycle is discarded.
  - No request or pop happens in a redirect cycle.
  - Issue resumes the following cycle, subject to credits (stale drops still consume credit).
- Simultaneous events:
  - Push and pop in the same cycle: count unchanged.
  - Request handshake and non-dropped response in the same cycle: outstanding unchanged.
  - Back-to-back redirects: each reloads target; drop_cnt accumulates correctly.
- Reset mid-operation: all in-flight and buffered state discarded immediately. Responses arriving after reset are not the block's concern; imem must be reset with it.

Test Plan:
- Reset release, RESET_PC=0x100, imem ready with 1-cycle response, instr_ready=1 -> requests 0x100, 0x104, 0x108…; instr_pc follows the same sequence; first instr_valid 2 cycles after first request.
- instr_ready=0, DEPTH=4 -> exactly 4 requests issued, then imem_req_valid=0; count=4. Release ready -> 4 pops in order with PCs +4 each, then issue resumes.
- 2 requests outstanding, beq=1 with branch_target=0x200 -> FIFO empty next cycle; the 2 late responses discarded; first instr_pc=0x200 with the correct word.
- jump=1 and blt=1 together, jump_target=0x400, branch_target=0x300 -> next request address 0x400.
- Redirect in a cycle with instr_valid pending and instr_ready=1 -> no pop that cycle; the old head never appears.
- imem_req_ready held 0 for 5 cycles -> imem_req_valid stays 1, address stable at fetch_pc. Assert rst=0 mid-stream -> outputs 0 and PC=RESET_PC immediately, without a clock edge.

Source files
------------

// File: rtl/riscv_fetch_unit_if.sv
// Fetch-unit bus bundle: imem request/response channels, redirect inputs from the data path and
// the instruction stream towards decode. The fetch unit uses the master modport.
interface riscv_fetch_unit_if #(
  parameter int unsigned XLEN = 32
);
  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_rsp_valid;
  logic [31:0]     imem_rsp_data;

  logic            jump;
  logic            beq;
  logic            bneq;
  logic            bge;
  logic            blt;
  logic [XLEN-1:0] jump_target;
  logic [XLEN-1:0] branch_target;

  logic            instr_valid;
  logic            instr_ready;
  logic [31:0]     instr_data;
  logic [XLEN-1:0] instr_pc;

  modport master (
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
    input  jump, beq, bneq, bge, blt, jump_target, branch_target,
    output instr_valid, instr_data, instr_pc,
    input  instr_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data,
    output jump, beq, bneq, bge, blt, jump_target, branch_target,
    input  instr_valid, instr_data, instr_pc,
    output instr_ready
  );
endinterface

// File: rtl/riscv_fetch_unit.sv
// Instruction-fetch front end: credit-limited sequential fetch, PC-tagged instruction FIFO and
// branch/jump redirect with discard of stale in-flight responses.
module riscv_fetch_unit #(
  parameter int unsigned    XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int unsigned    DEPTH    = 4
) (
  input logic                clk,
  input logic                rst,
  riscv_fetch_unit_if.master bus
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned SW = CW + 2;

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] head_pc_q, head_pc_d;
  logic [CW-1:0]   count_q, count_d;
  logic [CW-1:0]   outstanding_q, outstanding_d;
  logic [CW-1:0]   drop_cnt_q, drop_cnt_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [31:0]     fifo_q [DEPTH];

  logic            redirect;
  logic [XLEN-1:0] target;
  logic [SW-1:0]   in_use;
  logic            has_credit;
  logic            req_valid;
  logic            req_fire;
  logic            rsp_drop;
  logic            rsp_push;
  logic            head_valid;
  logic            pop;

  assign redirect = bus.jump | bus.beq | bus.bneq | bus.bge | bus.blt;

  always_comb begin
    target       = bus.jump ? bus.jump_target : bus.branch_target;
    target[1:0]  = 2'b00;
  end

  // Stale responses still to be discarded occupy credit just like live ones.
  assign in_use     = SW'(count_q) + SW'(outstanding_q) + SW'(drop_cnt_q);
  assign has_credit = in_use < SW'(DEPTH);

  // Gated by reset so the request stays low while reset is held.
  assign req_valid  = rst & ~redirect & has_credit;
  assign req_fire   = req_valid & bus.imem_req_ready;

  assign rsp_drop   = bus.imem_rsp_valid & (drop_cnt_q != '0);
  assign rsp_push   = bus.imem_rsp_valid & (drop_cnt_q == '0) & ~redirect;

  assign head_valid = (count_q != '0) & ~redirect;
  assign pop        = head_valid & bus.instr_ready;

  assign bus.imem_req_valid = req_valid;
  assign bus.imem_req_addr  = fetch_pc_q;
  assign bus.instr_valid    = head_valid;
  assign bus.instr_data     = fifo_q[rd_ptr_q];
  assign bus.instr_pc       = head_pc_q;

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    head_pc_d     = head_pc_q;
    count_d       = count_q;
    outstanding_d = outstanding_q;
    drop_cnt_d    = drop_cnt_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;

    if (redirect) begin
      // Every in-flight request becomes stale; one may be retiring right now.
      fetch_pc_d    = target;
      head_pc_d     = target;
      count_d       = '0;
      rd_ptr_d      = '0;
      wr_ptr_d      = '0;
      outstanding_d = '0;
      drop_cnt_d    = drop_cnt_q + outstanding_q - CW'(bus.imem_rsp_valid);
    end else begin
      if (req_fire) begin
        fetch_pc_d    = fetch_pc_q + XLEN'(4);
        outstanding_d = outstanding_d + CW'(1);
      end
      if (rsp_drop) begin
        drop_cnt_d = drop_cnt_q - CW'(1);
      end
      if (rsp_push) begin
        outstanding_d = outstanding_d - CW'(1);
        count_d       = count_d + CW'(1);
        wr_ptr_d      = wr_ptr_q + AW'(1);
      end
      if (pop) begin
        head_pc_d = head_pc_q + XLEN'(4);
        count_d   = count_d - CW'(1);
        rd_ptr_d  = rd_ptr_q + AW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc_q    <= RESET_PC;
      head_pc_q     <= RESET_PC;
      count_q       <= '0;
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      head_pc_q     <= head_pc_d;
      count_q       <= count_d;
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
    end
  end

  // Storage needs no reset: occupancy alone decides what is visible.
  always_ff @(posedge clk) begin
    if (rsp_push) begin
      fifo_q[wr_ptr_q] <= bus.imem_rsp_data;
    end
  end

  a_no_overflow : assert property (@(posedge clk) disable iff (!rst)
    rsp_push |-> (count_q < CW'(DEPTH)));

  a_rsp_expected : assert property (@(posedge clk) disable iff (!rst)
    bus.imem_rsp_valid |-> ((outstanding_q != '0) || (drop_cnt_q != '0)));

endmodule

// File: tb/tb_riscv_fetch_unit.sv
// Bench for riscv_fetch_unit: imem model plus a queue-based model of the fetch stream, driven by
// directed sequences, a redirect vector table and a randomized run.
module tb_riscv_fetch_unit;
  localparam int unsigned XLEN   = 32;
  localparam logic [31:0] RST_PC = 32'h100;
  localparam int unsigned DEPTH  = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;

  riscv_fetch_unit_if #(.XLEN(XLEN)) bus ();

  riscv_fetch_unit #(
    .XLEN    (XLEN),
    .RESET_PC(RST_PC),
    .DEPTH   (DEPTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    bit          stale;
  } req_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
  } ins_t;

  typedef struct {
    bit          j, b_eq, b_ne, b_ge, b_lt;
    logic [31:0] jt, bt, exp_addr;
  } vec_t;

  req_t        pend[$];
  ins_t        fq[$];
  logic [31:0] m_fetch;

  int tests = 0;
  int fails = 0;
  int rsp_pct = 100;
  int cyc = 0;
  int hs_cnt = 0;
  int pops_seen = 0;
  int first_req = -1;
  int first_iv = -1;
  bit          last_rv, last_iv;
  logic [31:0] last_ra, last_pc, last_data;

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic set_redirect(input bit j, input bit b0, input bit b1, input bit b2, input bit b3,
                              input logic [31:0] jt, input logic [31:0] bt);
    bus.jump = j; bus.beq = b0; bus.bneq = b1; bus.bge = b2; bus.blt = b3;
    bus.jump_target = jt; bus.branch_target = bt;
  endtask

  task automatic clear_redirect();
    set_redirect(0, 0, 0, 0, 0, $urandom, $urandom);
  endtask

  // One clock cycle: drive imem response, check outputs, then advance the model at the edge.
  task automatic step();
    bit          redir, mreq, hs, pop, rv, iv_exp;
    logic [31:0] tgt;
    req_t        e;
    if (pend.size() > 0 && $urandom_range(99) < rsp_pct) begin
      bus.imem_rsp_valid = 1'b1;
      bus.imem_rsp_data  = word_at(pend[0].addr);
    end else begin
      bus.imem_rsp_valid = 1'b0;
      bus.imem_rsp_data  = $urandom;
    end
    rv     = bus.imem_rsp_valid;
    redir  = bus.jump | bus.beq | bus.bneq | bus.bge | bus.blt;
    tgt    = (bus.jump ? bus.jump_target : bus.branch_target) & 32'hFFFF_FFFC;
    mreq   = !redir && (fq.size() + pend.size() < DEPTH);
    iv_exp = (fq.size() != 0) && !redir;
    #2;
    last_rv   = bus.imem_req_valid;
    last_ra   = bus.imem_req_addr;
    last_iv   = bus.instr_valid;
    last_pc   = bus.instr_pc;
    last_data = bus.instr_data;
    check("req_valid", last_rv, mreq);
    if (mreq) check("req_addr", last_ra, m_fetch);
    check("instr_valid", last_iv, iv_exp);
    if (iv_exp) begin
      check("instr_pc", last_pc, fq[0].pc);
      check("instr_data", last_data, fq[0].data);
    end
    if (last_rv && first_req < 0) first_req = cyc;
    if (last_iv && first_iv < 0) first_iv = cyc;
    if (last_rv && bus.imem_req_ready) hs_cnt++;
    if (last_iv && bus.instr_ready) pops_seen++;
    hs  = mreq && bus.imem_req_ready;
    pop = iv_exp && bus.instr_ready;
    @(posedge clk);
    if (redir) begin
      foreach (pend[i]) pend[i].stale = 1'b1;
      if (rv) void'(pend.pop_front());
      fq.delete();
      m_fetch = tgt;
    end else begin
      if (pop) void'(fq.pop_front());
      if (rv) begin
        e = pend.pop_front();
        if (!e.stale) fq.push_back('{pc: e.addr, data: word_at(e.addr)});
      end
      if (hs) begin
        pend.push_back('{addr: m_fetch, stale: 1'b0});
        m_fetch = m_fetch + 32'd4;
      end
    end
    cyc++;
    #1;
  endtask

  // Called at posedge+1; asserts reset between edges and checks outputs before any edge.
  task automatic mid_reset(input string tag);
    #2;
    rst = 1'b0;
    bus.imem_rsp_valid = 1'b0;
    #1;
    check({tag, "_req_valid"}, bus.imem_req_valid, 1'b0);
    check({tag, "_instr_valid"}, bus.instr_valid, 1'b0);
    check({tag, "_req_addr"}, bus.imem_req_addr, RST_PC);
    pend.delete();
    fq.delete();
    m_fetch = RST_PC;
    @(posedge clk);
    #1;
    check({tag, "_held_req_valid"}, bus.imem_req_valid, 1'b0);
    rst = 1'b1;
  endtask

  vec_t vecs[6];

  initial begin
    vecs[0] = '{j: 1, b_eq: 0, b_ne: 0, b_ge: 0, b_lt: 1, jt: 32'h400, bt: 32'h300,
                exp_addr: 32'h400};
    vecs[1] = '{j: 0, b_eq: 1, b_ne: 0, b_ge: 0, b_lt: 0, jt: 32'h500, bt: 32'h203,
                exp_addr: 32'h200};
    vecs[2] = '{j: 0, b_eq: 0, b_ne: 1, b_ge: 0, b_lt: 0, jt: 32'h600, bt: 32'h7F2,
                exp_addr: 32'h7F0};
    vecs[3] = '{j: 0, b_eq: 0, b_ne: 0, b_ge: 1, b_lt: 0, jt: 32'h1, bt: 32'hA08,
                exp_addr: 32'hA08};
    vecs[4] = '{j: 0, b_eq: 0, b_ne: 0, b_ge: 0, b_lt: 1, jt: 32'h0, bt: 32'hFFFF_FFFD,
                exp_addr: 32'hFFFF_FFFC};
    vecs[5] = '{j: 1, b_eq: 1, b_ne: 1, b_ge: 1, b_lt: 1, jt: 32'h1234_5677, bt: 32'h0,
                exp_addr: 32'h1234_5674};

    clear_redirect();
    bus.imem_req_ready = 1'b1;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = '0;
    bus.instr_ready    = 1'b1;
    m_fetch = RST_PC;

    // Reset state while held.
    repeat (2) @(posedge clk);
    #1;
    check("rst_req_valid", bus.imem_req_valid, 1'b0);
    check("rst_instr_valid", bus.instr_valid, 1'b0);
    check("rst_req_addr", bus.imem_req_addr, RST_PC);
    rst = 1'b1;

    // Streaming start: first instruction valid two cycles after the first request.
    first_req = -1;
    first_iv  = -1;
    rsp_pct   = 100;
    repeat (12) step();
    check("first_iv_latency", 64'(first_iv - first_req), 64'd2);

    // Decode stalled: credit limit caps issue at DEPTH, then drains in order.
    mid_reset("rst_a");
    bus.instr_ready = 1'b0;
    hs_cnt = 0;
    repeat (10) step();
    check("stall_req_count", 64'(hs_cnt), 64'(DEPTH));
    check("stall_req_valid_low", last_rv, 1'b0);
    bus.instr_ready = 1'b1;
    pops_seen = 0;
    repeat (4) step();
    check("drain_pops", 64'(pops_seen), 64'd4);
    repeat (4) step();

    // Branch with two requests in flight: late responses are dropped.
    mid_reset("rst_b");
    rsp_pct = 0;
    repeat (2) step();
    rsp_pct = 100;
    set_redirect(0, 1, 0, 0, 0, 32'h900, 32'h200);
    step();
    clear_redirect();
    step();
    check("br_fifo_empty", last_iv, 1'b0);
    check("br_req_addr", last_ra, 32'h200);
    for (int i = 0; i < 20; i++) begin
      step();
      if (last_iv) break;
    end
    check("br_first_valid", last_iv, 1'b1);
    check("br_first_pc", last_pc, 32'h200);
    check("br_first_data", last_data, word_at(32'h200));

    // Redirect while a head is ready to pop.
    bus.instr_ready = 1'b0;
    repeat (4) step();
    bus.instr_ready = 1'b1;
    set_redirect(0, 0, 0, 1, 0, 32'h0, 32'h3000);
    step();
    check("redir_no_pop", last_iv, 1'b0);
    clear_redirect();
    for (int i = 0; i < 20; i++) begin
      step();
      if (last_iv) break;
    end
    check("redir_new_head", last_pc, 32'h3000);

    // Redirect vector table: priority and target alignment.
    for (int v = 0; v < 6; v++) begin
      set_redirect(vecs[v].j, vecs[v].b_eq, vecs[v].b_ne, vecs[v].b_ge, vecs[v].b_lt,
                   vecs[v].jt, vecs[v].bt);
      step();
      check("vec_redirect_req_low", last_rv, 1'b0);
      clear_redirect();
      step();
      check("vec_req_valid", last_rv, 1'b1);
      check("vec_req_addr", last_ra, vecs[v].exp_addr);
      repeat (3) step();
    end

    // imem not ready: request held stable, then reset mid-stream.
    mid_reset("rst_c");
    bus.imem_req_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      check("hold_req_valid", last_rv, 1'b1);
      check("hold_req_addr", last_ra, RST_PC);
    end
    bus.imem_req_ready = 1'b1;
    repeat (6) step();
    mid_reset("rst_d");

    // Randomized traffic against the model.
    rsp_pct = 70;
    for (int i = 0; i < 1500; i++) begin
      bus.imem_req_ready = ($urandom_range(9) < 7);
      bus.instr_ready    = ($urandom_range(9) < 6);
      if ($urandom_range(7) == 0) begin
        int unsigned f;
        f = $urandom_range(31, 1);
        set_redirect(f[0], f[1], f[2], f[3], f[4], $urandom, $urandom);
      end else begin
        clear_redirect();
      end
      step();
      if ($urandom_range(299) == 0) begin
        clear_redirect();
        mid_reset("rst_rand");
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
